// File: rtl/bcd2dec.sv
// Sequential packed-BCD to unsigned binary converter (reverse double-dabble).
// Latency: done pulses 2*BIN_W+1 cycles after start is accepted; next start one cycle after done.
// Backpressure: none queued; start is only honoured in IDLE, ignored while busy or in DONE.
//
// Ports:
//   clk, rst      - rising-edge clock, synchronous active-high reset
//   start, bcd_in - conversion request and packed BCD operand (sampled on acceptance only)
//   busy, done    - conversion in progress / single-cycle result-update pulse
//   dec_out, err  - binary result and invalid-digit flag, held until the next done
module bcd2dec #(
  parameter int BCD_DIGITS = 2,
  parameter int BIN_W      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [4*BCD_DIGITS-1:0] bcd_in,
  output logic                    busy,
  output logic                    done,
  output logic [BIN_W-1:0]        dec_out,
  output logic                    err
);

  localparam int BCD_W  = 4 * BCD_DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_ADJ,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  // {bcd part, bin part}: digits drain out of the top into the bin part one bit per shift
  logic [WORK_W-1:0]   work_q, work_d;
  logic                inv_q, inv_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [BIN_W-1:0]    dec_q, dec_d;
  logic                err_q, err_d;
  logic                bad_digit;

  // Any nibble above 9 marks the whole operand invalid
  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    inv_d   = inv_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dec_d   = dec_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          work_d  = {bcd_in, {BIN_W{1'b0}}};
          cnt_d   = '0;
          inv_d   = bad_digit;
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        work_d  = work_q >> 1;
        state_d = S_ADJ;
      end

      S_ADJ: begin
        // A nibble >= 8 after the shift means a tens-of-the-digit-below carry of 10
        // landed as 16 (binary weight 8); subtracting 3 restores the BCD value.
        for (int i = 0; i < BCD_DIGITS; i++) begin
          if (work_q[BIN_W+4*i +: 4] >= 4'd8) begin
            work_d[BIN_W+4*i +: 4] = work_q[BIN_W+4*i +: 4] - 4'd3;
          end
        end
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_SHIFT;
        end
      end

      S_DONE: begin
        dec_d   = inv_q ? '0 : work_q[BIN_W-1:0];
        err_d   = inv_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      inv_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dec_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      inv_q   <= inv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dec_q   <= dec_d;
      err_q   <= err_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign dec_out = dec_q;
  assign err     = err_q;

endmodule

// File: tb/tb_bcd2dec.sv
// Scoreboard bench for bcd2dec: driver pushes expected results, monitor pops on done.
module tb_bcd2dec;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] bcd_in;
  logic       busy;
  logic       done;
  logic [7:0] dec_out;
  logic       err;

  typedef struct {
    logic [7:0] dec;
    logic       err;
    int         e0;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  int   dones  = 0;

  bcd2dec #(.BCD_DIGITS(2), .BIN_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .dec_out (dec_out),
    .err     (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference: a BCD byte is tens*10 + units; any digit above 9 is an error.
  function automatic exp_t model(input logic [7:0] b, input int e0);
    exp_t r;
    int tens, units;
    tens  = b / 16;
    units = b % 16;
    r.e0 = e0;
    if (tens > 9 || units > 9) begin
      r.dec = 8'd0;
      r.err = 1'b1;
    end else begin
      r.dec = 8'(tens * 10 + units);
      r.err = 1'b0;
    end
    return r;
  endfunction

  // Call from a negedge while the DUT is idle; returns just after the accepting edge.
  task automatic issue(input logic [7:0] b, input bit push);
    start  = 1'b1;
    bcd_in = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) exp_q.push_back(model(b, cyc));
    chk("accept_busy", 32'(busy), 32'd1);
  endtask

  // Returns at the negedge inside the done cycle.
  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      $display("FAIL done_timeout: no done within 40 cycles (cycle %0d)", cyc);
    end
  endtask

  // Monitor
  initial begin
    logic prev_busy;
    logic prev_done;
    exp_t e;
    prev_busy = 1'b0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_done) chk("done_single_cycle", 32'(done), 32'd0);
      if (done) begin
        dones++;
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL spurious_done: got done with dec_out %0d, expected none (cycle %0d)", dec_out, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("dec_out", 32'(dec_out), 32'(e.dec));
          chk("err", 32'(err), 32'(e.err));
          chk("latency", 32'(cyc - e.e0), 32'd17);
          chk("busy_low_in_done", 32'(busy), 32'd0);
          chk("busy_before_done", 32'(prev_busy), 32'd1);
        end
      end
      prev_busy = busy;
      prev_done = done;
    end
  end

  initial begin
    logic [7:0] seq[4];
    logic [7:0] r;
    rst    = 1'b1;
    start  = 1'b0;
    bcd_in = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_dec", 32'(dec_out), 32'd0);
    chk("reset_err", 32'(err), 32'd0);

    // Max value, then back-to-back restarts one cycle after done
    @(negedge clk);
    issue(8'h99, 1'b1);
    wait_done();
    seq[0] = 8'h00; seq[1] = 8'h09; seq[2] = 8'h10; seq[3] = 8'h42;
    for (int i = 0; i < 4; i++) begin
      issue(seq[i], 1'b1);
      wait_done();
    end

    // Invalid then valid
    issue(8'h3A, 1'b1);
    wait_done();
    issue(8'h57, 1'b1);
    wait_done();

    // Start while busy with changed operand is ignored
    issue(8'h25, 1'b1);
    repeat (4) @(negedge clk);
    start  = 1'b1;
    bcd_in = 8'h77;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();
    repeat (20) @(negedge clk);

    // Reset mid-conversion aborts without a done pulse
    issue(8'h64, 1'b0);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_dec", 32'(dec_out), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    repeat (25) @(negedge clk);
    issue(8'h55, 1'b1);
    wait_done();

    // Exhaustive sweep of every byte code
    for (int c = 0; c < 256; c++) begin
      issue(8'(c), 1'b1);
      wait_done();
    end

    // Random codes with random idle gaps
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      r = 8'($urandom_range(0, 255));
      issue(r, 1'b1);
      wait_done();
    end

    repeat (25) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
